// File: rtl/warrants_index_loader.sv
// warrants_index_loader
//   Control-plane front end for the warrants index RAM (2^ADDR_WIDTH x
//   DATA_WIDTH, single port, 1-cycle registered read). Accepts write,
//   read-back and clear-all commands on a valid/ready command channel, drives
//   the RAM port and returns read words on a valid/ready response channel.
//
// Ports
//   axis_aclk, axis_resetn         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op                         00 write, 01 read, 10 clear-all, 11 illegal
//   cmd_addr, cmd_data             target entry and write word
//   rsp_valid/rsp_ready            response handshake
//   rsp_addr, rsp_data             address and word of a completed read
//   ram_addr, ram_din, ram_we      RAM port A drive
//   ram_dout                       RAM port A read data (valid 1 cycle after addr)
//   busy                           command in progress
//   clear_done                     pulse the cycle after the final clear write
//   illegal_cmd                    pulse after an op=11 command is accepted
//   wr_count                       accepted write commands, saturating
module warrants_index_loader #(
  parameter int                    ADDR_WIDTH  = 11,
  parameter int                    DATA_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  illegal_cmd,
  output logic [31:0]           wr_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RSP      = 3'd4,
    CLEAR    = 3'd5
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_ILLEG = 2'b11;

  // One bit wider than the address so the sweep ends on the last entry
  // without wrapping back to 0.
  localparam logic [ADDR_WIDTH:0] CLR_ONE = 1;
  localparam logic [ADDR_WIDTH:0] CLR_END = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [31:0]         CNT_MAX = 32'hFFFF_FFFF;

  state_t                state;
  state_t                next_state;
  logic                  accept;
  logic [ADDR_WIDTH:0]   clr_cnt;
  logic [31:0]           wr_count_nxt;

  assign accept = cmd_valid & cmd_ready;

  // State register
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state <= IDLE;
    else              state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: next_state = WRITE;
            OP_READ:  next_state = RD_ISSUE;
            OP_CLEAR: next_state = CLEAR;
            default:  next_state = IDLE;
          endcase
        end
      end
      WRITE:    next_state = IDLE;
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT:  next_state = RSP;
      RSP:      if (rsp_ready) next_state = IDLE;
      // clr_cnt holds the address to be presented next; reaching CLR_END
      // means the word on ram_addr this cycle is the final one.
      CLEAR:    if (clr_cnt == CLR_END) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    wr_count_nxt = wr_count;
    if (accept && (cmd_op == OP_WRITE) && (wr_count != CNT_MAX))
      wr_count_nxt = wr_count + 32'd1;
  end

  // Registered outputs, derived from the upcoming state so that every output
  // reflects the state it belongs to in the same cycle.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      rsp_valid   <= 1'b0;
      rsp_addr    <= '0;
      rsp_data    <= '0;
      clear_done  <= 1'b0;
      illegal_cmd <= 1'b0;
      wr_count    <= '0;
      clr_cnt     <= '0;
    end else begin
      cmd_ready   <= (next_state == IDLE);
      busy        <= (next_state != IDLE);
      ram_we      <= (next_state == WRITE) || (next_state == CLEAR);
      clear_done  <= (state == CLEAR) && (next_state == IDLE);
      illegal_cmd <= accept && (cmd_op == OP_ILLEG);
      wr_count    <= wr_count_nxt;

      if (accept) begin
        case (cmd_op)
          OP_WRITE: begin
            ram_addr <= cmd_addr;
            ram_din  <= cmd_data;
          end
          OP_READ:  ram_addr <= cmd_addr;
          OP_CLEAR: begin
            ram_addr <= '0;
            ram_din  <= CLEAR_VALUE;
            clr_cnt  <= CLR_ONE;
          end
          default: ;
        endcase
      end

      if ((state == CLEAR) && (next_state == CLEAR)) begin
        ram_addr <= clr_cnt[ADDR_WIDTH-1:0];
        clr_cnt  <= clr_cnt + CLR_ONE;
      end

      // ram_addr still carries the read address while the RAM returns data.
      if (state == RD_WAIT) begin
        rsp_valid <= 1'b1;
        rsp_data  <= ram_dout;
        rsp_addr  <= ram_addr;
      end

      if ((state == RSP) && rsp_ready)
        rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_warrants_index_loader.sv
module tb_warrants_index_loader;

  logic        clk;
  logic        axis_resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [10:0] cmd_addr;
  logic [11:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [10:0] rsp_addr;
  logic [11:0] rsp_data;
  logic [10:0] ram_addr;
  logic [11:0] ram_din;
  logic        ram_we;
  logic [11:0] ram_dout;
  logic        busy;
  logic        clear_done;
  logic        illegal_cmd;
  logic [31:0] wr_count;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_wr = 0;

  warrants_index_loader #(
    .ADDR_WIDTH (11),
    .DATA_WIDTH (12),
    .CLEAR_VALUE(12'h000)
  ) dut (
    .axis_aclk  (clk),
    .axis_resetn(axis_resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_addr   (rsp_addr),
    .rsp_data   (rsp_data),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .busy       (busy),
    .clear_done (clear_done),
    .illegal_cmd(illegal_cmd),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index RAM model: single port, read-first, 1-cycle registered read.
  logic [11:0] mem [2048];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [1:0] op, input logic [10:0] a, input logic [11:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [11:0] d);
    send(2'b00, a, d);
    if (exp_wr != 32'hFFFF_FFFF) exp_wr = exp_wr + 1;
    check("wr_we",    {31'd0, ram_we}, 32'd1);
    check("wr_addr",  {21'd0, ram_addr}, {21'd0, a});
    check("wr_din",   {20'd0, ram_din}, {20'd0, d});
    check("wr_count", wr_count, exp_wr);
    @(negedge clk);
    check("wr_we_off", {31'd0, ram_we}, 32'd0);
  endtask

  task automatic rd(input logic [10:0] a, input logic [11:0] exp_d);
    send(2'b01, a, 12'h000);
    check("rd_vld_t1", {31'd0, rsp_valid}, 32'd0);
    check("rd_we_t1",  {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    check("rd_vld_t2", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("rd_vld_t3", {31'd0, rsp_valid}, 32'd1);
    check("rd_data",   {20'd0, rsp_data}, {20'd0, exp_d});
    check("rd_addr",   {21'd0, rsp_addr}, {21'd0, a});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_vld_drop", {31'd0, rsp_valid}, 32'd0);
    check("rd_rdy_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int idx, bad, done_cnt, rdy_bad, n;
    logic seen;
    axis_resetn = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_addr    = '0;
    cmd_data    = '0;
    rsp_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_we",        {31'd0, ram_we}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_wr_count",  wr_count, 32'd0);
    axis_resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: write then read back
    wr(11'h005, 12'hABC);
    rd(11'h005, 12'hABC);
    check("t1_wr_count", wr_count, 32'd1);

    // 2: response back-pressure
    wr(11'h123, 12'h5A5);
    send(2'b01, 11'h123, 12'h000);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data",  {20'd0, rsp_data}, 32'h5A5);
      check("bp_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("bp_ready_same", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("bp_ready_back", {31'd0, cmd_ready}, 32'd1);

    // 3: clear-all sweep
    wr(11'h000, 12'hFFF);
    wr(11'h7FF, 12'hFFF);
    send(2'b10, 11'h3AA, 12'h777);
    idx = 0; bad = 0; done_cnt = 0; rdy_bad = 0; seen = 1'b0;
    for (int i = 0; i < 2100 && !seen; i++) begin
      if (ram_we) begin
        if (ram_addr !== 11'(idx) || ram_din !== 12'h000) bad++;
        idx++;
      end
      if (clear_done) begin
        done_cnt++;
        seen = 1'b1;
        check("clr_done_we",   {31'd0, ram_we}, 32'd0);
        check("clr_done_busy", {31'd0, busy}, 32'd0);
      end else if (cmd_ready) rdy_bad++;
      @(negedge clk);
    end
    check("clr_writes",    idx, 32'd2048);
    check("clr_seq_bad",   bad, 32'd0);
    check("clr_done_cnt",  done_cnt, 32'd1);
    check("clr_ready_low", rdy_bad, 32'd0);
    check("clr_done_once", {31'd0, clear_done}, 32'd0);
    check("clr_wr_count",  wr_count, exp_wr);
    rd(11'h000, 12'h000);
    rd(11'h7FF, 12'h000);

    // 4: illegal op
    send(2'b11, 11'h010, 12'h111);
    check("ill_pulse", {31'd0, illegal_cmd}, 32'd1);
    check("ill_we",    {31'd0, ram_we}, 32'd0);
    check("ill_ready", {31'd0, cmd_ready}, 32'd1);
    check("ill_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("ill_pulse_end", {31'd0, illegal_cmd}, 32'd0);
    check("ill_wr_count",  wr_count, exp_wr);

    // 5: reset in the middle of a clear
    wr(11'd999,  12'h111);
    wr(11'd1000, 12'h222);
    wr(11'd1500, 12'h333);
    send(2'b10, 11'h000, 12'h000);
    n = 0;
    while (!(ram_we && ram_addr == 11'd1000) && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("mid_clr_addr", {21'd0, ram_addr}, 32'd1000);
    axis_resetn = 1'b0;
    #1;
    check("arst_we",       {31'd0, ram_we}, 32'd0);
    check("arst_addr",     {21'd0, ram_addr}, 32'd0);
    check("arst_busy",     {31'd0, busy}, 32'd0);
    check("arst_ready",    {31'd0, cmd_ready}, 32'd0);
    check("arst_wr_count", wr_count, 32'd0);
    exp_wr = 0;
    @(negedge clk);
    axis_resetn = 1'b1;
    @(negedge clk);
    check("arst_ready_back", {31'd0, cmd_ready}, 32'd1);
    rd(11'd999,  12'h000);
    rd(11'd1000, 12'h222);
    rd(11'd1500, 12'h333);

    // 6: wr_count saturation
    force dut.wr_count = 32'hFFFF_FFFD;
    @(negedge clk);
    @(negedge clk);
    release dut.wr_count;
    @(negedge clk);
    check("sat_preload", wr_count, 32'hFFFF_FFFD);
    exp_wr = 32'hFFFF_FFFD;
    wr(11'h001, 12'h001);
    wr(11'h002, 12'h002);
    wr(11'h003, 12'h003);
    check("sat_hold", wr_count, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
